// File: rtl/cve2_rvfi_trace_buffer_pkg.sv
// Shared types for the RVFI retirement trace buffer: record layout, capture
// states, capture modes and the PC window filter.
package cve2_rvfi_trace_buffer_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        intr;
  } trace_rec_t;

  typedef enum logic [1:0] {
    TRACE_IDLE   = 2'd0,
    TRACE_ARMED  = 2'd1,
    TRACE_POST   = 2'd2,
    TRACE_FROZEN = 2'd3
  } trace_state_e;

  typedef enum logic {
    TRACE_FIFO = 1'b0,
    TRACE_RING = 1'b1
  } trace_mode_e;

  function automatic logic pc_in_window(input logic [31:0] pc,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
    return (pc >= lo) && (pc <= hi);
  endfunction

endpackage

// File: rtl/cve2_trace_ring_mem.sv
// Depth-entry record store with wrapping pointers, level tracking and an
// optional overwrite-oldest policy when full.
module cve2_trace_ring_mem
  import cve2_rvfi_trace_buffer_pkg::*;
#(
  parameter int unsigned Depth = 16,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LvlW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic            overwrite_i,
  input  logic            pop_i,
  input  trace_rec_t      wdata_i,
  output trace_rec_t      rdata_o,
  output logic            full_o,
  output logic [LvlW-1:0] level_o,
  output logic [LvlW-1:0] level_nxt_o
);

  trace_rec_t      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            full, do_pop, do_push, drop_oldest;

  assign full        = (level_q == LvlW'(Depth));
  assign do_pop      = pop_i && (level_q != '0);
  assign do_push     = push_i && (!full || do_pop || overwrite_i);
  // Overwriting when full retires the oldest entry without changing the level.
  assign drop_oldest = do_push && full && !do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop || drop_oldest) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop && !drop_oldest) level_d = level_q + LvlW'(1);
    else if (do_pop && !do_push) level_d = level_q - LvlW'(1);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    wr_ptr_q <= wr_ptr_d;
    rd_ptr_q <= rd_ptr_d;
    level_q  <= level_d;
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o     = mem_q[rd_ptr_q];
  assign full_o      = full;
  assign level_o     = level_q;
  assign level_nxt_o = level_d;

endmodule

// File: rtl/cve2_rvfi_trace_buffer.sv
// RVFI retirement trace capture: filter, FIFO streaming or RING capture with
// trigger and post-trigger count, drained through a valid/ready read port.
module cve2_rvfi_trace_buffer
  import cve2_rvfi_trace_buffer_pkg::*;
#(
  parameter int unsigned Depth        = 16,
  parameter int unsigned DropCntWidth = 16,
  localparam int unsigned LvlW        = $clog2(Depth) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic                    mode_i,
  input  logic                    filt_win_i,
  input  logic [31:0]             pc_lo_i,
  input  logic [31:0]             pc_hi_i,
  input  logic [31:0]             trig_pc_i,
  input  logic [LvlW-1:0]         post_trig_i,
  input  logic                    rvfi_valid_i,
  input  logic [31:0]             rvfi_pc_rdata_i,
  input  logic [31:0]             rvfi_insn_i,
  input  logic                    rvfi_trap_i,
  input  logic                    rvfi_intr_i,
  input  logic [4:0]              rvfi_rd_addr_i,
  input  logic [31:0]             rvfi_rd_wdata_i,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  output logic [102:0]            rd_rec_o,
  output logic [LvlW-1:0]         level_o,
  output logic [1:0]              state_o,
  output logic                    triggered_o,
  output logic                    overflow_o,
  output logic [DropCntWidth-1:0] drop_cnt_o
);

  trace_state_e            state_q, state_d;
  trace_mode_e             mode_q, mode_d;
  logic [LvlW-1:0]         remain_q, remain_d;
  logic                    triggered_q, triggered_d;
  logic                    overflow_q, overflow_d;
  logic [DropCntWidth-1:0] drop_cnt_q, drop_cnt_d;
  logic                    rd_valid_q, rd_valid_d;

  logic            flush, qual, is_trig, push, pop, full, drop;
  logic [LvlW-1:0] post_eff, level, level_nxt;
  trace_rec_t      wrec, rrec;

  assign flush    = rst_i || clear_i;
  assign wrec     = '{pc: rvfi_pc_rdata_i, insn: rvfi_insn_i, rd_addr: rvfi_rd_addr_i,
                      rd_wdata: rvfi_rd_wdata_i, trap: rvfi_trap_i, intr: rvfi_intr_i};
  assign qual     = rvfi_valid_i &&
                    (!filt_win_i || pc_in_window(rvfi_pc_rdata_i, pc_lo_i, pc_hi_i));
  assign is_trig  = qual && (rvfi_trap_i || rvfi_intr_i || (rvfi_pc_rdata_i == trig_pc_i));
  assign post_eff = (post_trig_i > LvlW'(Depth)) ? LvlW'(Depth) : post_trig_i;
  assign pop      = rd_valid_q && rd_ready_i;

  cve2_trace_ring_mem #(.Depth(Depth)) u_mem (
    .clk_i       (clk_i),
    .flush_i     (flush),
    .push_i      (push),
    .overwrite_i (mode_q == TRACE_RING),
    .pop_i       (pop),
    .wdata_i     (wrec),
    .rdata_o     (rrec),
    .full_o      (full),
    .level_o     (level),
    .level_nxt_o (level_nxt)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    remain_d    = remain_q;
    triggered_d = triggered_q;
    push        = 1'b0;
    drop        = 1'b0;
    unique case (state_q)
      TRACE_IDLE: begin
        if (enable_i) begin
          state_d = TRACE_ARMED;
          mode_d  = trace_mode_e'(mode_i);
        end
      end
      TRACE_ARMED: begin
        if (!enable_i) begin
          state_d = (mode_q == TRACE_FIFO) ? TRACE_IDLE : TRACE_FROZEN;
        end else if (mode_q == TRACE_FIFO) begin
          push = qual;
          drop = qual && full && !pop;
        end else begin
          push = qual;
          if (is_trig) begin
            triggered_d = 1'b1;
            remain_d    = post_eff;
            state_d     = (post_eff == '0) ? TRACE_FROZEN : TRACE_POST;
          end
        end
      end
      TRACE_POST: begin
        if (!enable_i) begin
          state_d = TRACE_FROZEN;
        end else if (qual) begin
          push     = 1'b1;
          remain_d = remain_q - LvlW'(1);
          if (remain_q == LvlW'(1)) state_d = TRACE_FROZEN;
        end
      end
      default: begin
        if ((level == '0) || ((level == LvlW'(1)) && pop)) state_d = TRACE_IDLE;
      end
    endcase
  end

  // Saturating drop counter; overflow stays set until flushed.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DropCntWidth'(1);
    end
  end

  // Capturing RING states hide the buffer from the reader.
  assign rd_valid_d = (level_nxt != '0) &&
                      !((mode_d == TRACE_RING) &&
                        ((state_d == TRACE_ARMED) || (state_d == TRACE_POST)));

  always_ff @(posedge clk_i) begin
    if (flush) begin
      state_q     <= TRACE_IDLE;
      mode_q      <= TRACE_FIFO;
      remain_q    <= '0;
      triggered_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      remain_q    <= remain_d;
      triggered_q <= triggered_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign rd_valid_o  = rd_valid_q;
  assign rd_rec_o    = rrec;
  assign level_o     = level;
  assign state_o     = state_q;
  assign triggered_o = triggered_q;
  assign overflow_o  = overflow_q;
  assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: doc/cve2_rvfi_trace_buffer.md
Name: cve2_rvfi_trace_buffer

Overview:
Parametrised on-chip retirement trace capture unit that sits beside cve2_top on its RVFI outputs. It records filtered retirement records into a Depth-entry buffer and supports two modes. FIFO mode streams records out continuously. RING mode is a logic-analyser style capture: pre-trigger history, a trigger, a programmable post-trigger count, then freeze. Captured records drain through a valid/ready read port to a debug or bus bridge.

Parameters:
Depth, 16, buffer entries; power of two, >=2.
DropCntWidth, 16, width of the saturating dropped-record counter.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
enable_i  in  1  capture enable
clear_i  in  1  synchronous flush: empty buffer, clear sticky state, go to IDLE
mode_i  in  1  0=FIFO, 1=RING; sampled only in IDLE
filt_win_i  in  1  1=record only when pc_lo_i <= pc <= pc_hi_i (unsigned, inclusive)
pc_lo_i  in  32  filter window low bound
pc_hi_i  in  32  filter window high bound
trig_pc_i  in  32  RING trigger PC
post_trig_i  in  $clog2(Depth)+1  records captured after the trigger (0..Depth)
rvfi_valid_i  in  1  retirement strobe
rvfi_pc_rdata_i  in  32  retired PC
rvfi_insn_i  in  32  retired instruction
rvfi_trap_i  in  1  trap
rvfi_intr_i  in  1  first instruction of handler
rvfi_rd_addr_i  in  5  destination register
rvfi_rd_wdata_i  in  32  destination write data
rd_valid_o  out  1  record available
rd_ready_i  in  1  consumer accepts
rd_rec_o  out  103  trace_rec_t: {pc, insn, rd_addr, rd_wdata, trap, intr}
level_o  out  $clog2(Depth)+1  stored entry count
state_o  out  2  capture state
triggered_o  out  1  sticky; RING trigger has fired
overflow_o  out  1  sticky; a qualified record was dropped (FIFO full)
drop_cnt_o  out  DropCntWidth  dropped records, saturating

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE; pointers=0; level_o=0; rd_valid_o=0; triggered_o=0; overflow_o=0; drop_cnt_o=0. rd_rec_o contents are don't-care while rd_valid_o=0. clear_i has identical effect and has priority over every other event.
- Qualified record: rvfi_valid_i=1 and (filt_win_i=0 or PC inside the window).
- Storage: flop array with write and read pointers of $clog2(Depth) bits that wrap modulo Depth. rd_rec_o is read combinationally at the read pointer. A record accepted at edge N is visible on rd_* after edge N.
- States: IDLE=0, ARMED=1, POST=2, FROZEN=3.
- IDLE: no capture. Goes to ARMED when enable_i=1; mode is latched on that transition. Reads are allowed in IDLE so the buffer can finish draining.
- FIFO mode, ARMED:
  - A qualified record is written if level<Depth.
  - If the FIFO is full and no pop happens in the same cycle, the record is dropped: overflow_o is set and drop_cnt_o increments, saturating at all-ones.
  - Push and pop in the same cycle when full: the push is accepted and level is unchanged.
  - enable_i=0 returns the block to IDLE; stored data is retained.
  - rd_valid_o = level>0.
- RING mode, ARMED:
  - rd_valid_o=0 throughout.
  - A qualified record is always written. When full, it overwrites the oldest entry: the read pointer advances and level stays at Depth. Overwrites do not count as drops.
  - Trigger: qualified record with trap, intr, or pc==trig_pc_i. The triggering record is stored and triggered_o is set.
  - After the trigger: go to FROZEN if post_trig_i==0, otherwise to POST with remaining=post_trig_i.
- RING mode, POST: each qualified record is stored, using the same overwrite rule, and decrements remaining. The block enters FROZEN on the edge that stores the last post-trigger record.
- enable_i=0 in ARMED or POST forces FROZEN (manual stop) with triggered_o unchanged.
- FROZEN: captures are ignored. rd_valid_o = level>0. When level reaches 0, go to IDLE.
- Pop occurs when rd_valid_o and rd_ready_i are both 1. The read pointer advances and level decrements.
- level_o never exceeds Depth. post_trig_i values above Depth are clamped to Depth.

Decomposition:
- cve2_pkg additions:
  - trace_rec_t, a packed struct of 103 bits.
  - trace_state_e, a 2-bit enum.
  - trace_mode_e.
- One sub-module, cve2_trace_ring_mem. It holds the Depth x trace_rec_t flop array, the pointers, the level, and the push, pop and overwrite logic.
- The FSM, filter, trigger and drop counter stay in the top of this block.

Test Plan:
- FIFO, Depth=16, 10 records, rd_ready_i=1 throughout -> 10 pops in order, each appearing one cycle after its push; level_o returns to 0; overflow_o=0.
- FIFO, rd_ready_i=0, 20 qualified records -> level_o=16; drop_cnt_o=4; overflow_o=1. Then one simultaneous push and pop -> level_o stays 16 and drop_cnt_o stays 4.
- RING, post_trig_i=4, 30 records with a trap on record #20 -> FROZEN after record #24; drain yields records #9..#24 in order; triggered_o=1; then state returns to IDLE.
- filt_win_i=1, window 0x100..0x1FC, PCs 0x0F8, 0x100, 0x1FC, 0x200 -> only 0x100 and 0x1FC are stored.
- RING, trig_pc_i=0x80, post_trig_i=0, match on the 3rd record -> immediate FROZEN with 3 entries; a clear_i pulse mid-drain -> level_o=0, IDLE, sticky flags cleared.
- rst_i asserted in POST with 7 entries -> next cycle all outputs at reset values and rvfi input is ignored until enable_i is asserted.
